// File: rtl/block_quantizer_if.sv
// Handshake bundle for block_quantizer: group capture in, quantized stream out.
// Ports: start/in_flat/out_ready (master->slave), busy/out_valid/out_data/out_shift/out_last (slave->master).
interface block_quantizer_if #(
  parameter int LENGTH = 16,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8
);
  localparam int SW = $clog2(IN_W + 1);

  logic                     start;
  logic [LENGTH*IN_W-1:0]   in_flat;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [SW-1:0]            out_shift;
  logic                     out_last;

  modport master (
    output start, in_flat, out_ready,
    input  busy, out_valid, out_data, out_shift, out_last
  );

  modport slave (
    input  start, in_flat, out_ready,
    output busy, out_valid, out_data, out_shift, out_last
  );
endinterface

// File: rtl/block_quantizer.sv
// Block floating-point quantizer: snapshot a group, find max |x|, shared shift, stream saturated values.
// Ports: clk, rst (sync, active-high), bus (block_quantizer_if.slave). Option: QUANT_ROUND_EN = round half up.
module block_quantizer #(
  parameter int LENGTH = 16,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  block_quantizer_if.slave   bus
);
  localparam int SW    = $clog2(IN_W + 1);
  localparam int IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int QW    = IN_W + 1;
  localparam int QMAXI = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [QW-1:0] QMAX = QW'(QMAXI);
  localparam logic signed [QW-1:0] QMIN = -QMAX;
  localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, CALC, EMIT} state_t;

  state_t                  state;
  logic signed [IN_W-1:0]  xr [LENGTH];
  logic [IW-1:0]           idx;
  logic [IW-1:0]           nidx;
  logic [IN_W-1:0]         maxabs;
  logic [IN_W-1:0]         absx;
  logic [SW-1:0]           blen;
  logic [SW-1:0]           shift_c;
  logic [SW-1:0]           sh_sel;
  logic signed [IN_W-1:0]  x_sel;
  logic signed [QW-1:0]    xe;
  logic signed [QW-1:0]    ys;
  logic [OUT_W-1:0]        q;
`ifdef QUANT_ROUND_EN
  logic signed [QW-1:0]    rnd;
`endif

  logic                    busy_r;
  logic                    valid_r;
  logic                    last_r;
  logic [OUT_W-1:0]        data_r;
  logic [SW-1:0]           shift_r;

  assign bus.busy      = busy_r;
  assign bus.out_valid = valid_r;
  assign bus.out_last  = last_r;
  assign bus.out_data  = data_r;
  assign bus.out_shift = shift_r;

  // Unsigned magnitude; -2^(IN_W-1) maps to 2^(IN_W-1) without overflow.
  assign absx = xr[idx][IN_W-1] ? (~xr[idx] + IN_W'(1)) : xr[idx];

  always_comb begin
    blen = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (maxabs[i]) blen = SW'(i + 1);
    end
  end

  assign shift_c = (blen > SW'(OUT_W - 1)) ? blen - SW'(OUT_W - 1) : '0;
  assign nidx    = (idx == LAST) ? '0 : idx + IW'(1);

  // One quantizer: CALC preloads element 0 with the fresh shift,
  // EMIT preloads the next element with the latched shift.
  assign x_sel  = (state == CALC) ? xr[0] : xr[nidx];
  assign sh_sel = (state == CALC) ? shift_c : shift_r;

  always_comb begin
    xe = {x_sel[IN_W-1], x_sel};
`ifdef QUANT_ROUND_EN
    rnd = (sh_sel == '0) ? '0 : (QW'(1) <<< (sh_sel - SW'(1)));
    xe  = xe + rnd;
`endif
    ys = xe >>> sh_sel;
    if (ys > QMAX)      q = QMAX[OUT_W-1:0];
    else if (ys < QMIN) q = QMIN[OUT_W-1:0];
    else                q = ys[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      maxabs  <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
      shift_r <= '0;
      for (int i = 0; i < LENGTH; i++) xr[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < LENGTH; i++)
              xr[i] <= bus.in_flat[i*IN_W +: IN_W];
            idx    <= '0;
            maxabs <= '0;
            busy_r <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (absx > maxabs) maxabs <= absx;
          idx <= nidx;
          if (idx == LAST) state <= CALC;
        end
        CALC: begin
          shift_r <= shift_c;
          data_r  <= q;
          valid_r <= 1'b1;
          last_r  <= (LAST == '0);
          idx     <= '0;
          state   <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (last_r) begin
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              busy_r  <= 1'b0;
              state   <= IDLE;
            end else begin
              idx    <= nidx;
              data_r <= q;
              last_r <= (nidx == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_quantizer.sv
// Self-checking bench for block_quantizer: behavioural group model, per-cycle output compare.
// Ports: none; drives block_quantizer_if master side.
module tb_block_quantizer;
  localparam int LENGTH = 16;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 8;

  typedef int grp_t [LENGTH];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_quantizer_if #(.LENGTH(LENGTH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  block_quantizer #(.LENGTH(LENGTH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int exp_d[$];
  int exp_s[$];
  int exp_l[$];
  int hs_cnt = 0;

  function automatic int m_shift(input grp_t xs);
    int mx = 0;
    int l = 0;
    foreach (xs[i]) begin
      int a = (xs[i] < 0) ? -xs[i] : xs[i];
      if (a > mx) mx = a;
    end
    while (mx >= (1 << l)) l++;
    return (l > OUT_W - 1) ? l - (OUT_W - 1) : 0;
  endfunction

  function automatic int m_q(input int x, input int sh);
    int y;
    int lim = (1 << (OUT_W - 1)) - 1;
`ifdef QUANT_ROUND_EN
    y = (sh > 0) ? ((x + (1 << (sh - 1))) >>> sh) : x;
`else
    y = x >>> sh;
`endif
    if (y > lim) y = lim;
    if (y < -lim) y = -lim;
    return y;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: data %0d with nothing expected",
                 $signed(bus.out_data));
      end else begin
        if (int'($signed(bus.out_data)) != exp_d[0] ||
            int'(bus.out_shift) != exp_s[0] ||
            int'(bus.out_last) != exp_l[0]) begin
          errors++;
          $display("FAIL stream: got d=%0d s=%0d l=%0d expected d=%0d s=%0d l=%0d",
                   $signed(bus.out_data), bus.out_shift, bus.out_last,
                   exp_d[0], exp_s[0], exp_l[0]);
        end
        if (bus.out_ready) begin
          void'(exp_d.pop_front());
          void'(exp_s.pop_front());
          void'(exp_l.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  task automatic check_idle(input string name);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_valid"}, int'(bus.out_valid), 0);
    chk({name, "_last"}, int'(bus.out_last), 0);
    chk({name, "_data"}, int'(bus.out_data), 0);
    chk({name, "_shift"}, int'(bus.out_shift), 0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 stall 5 cycles on element 3
  // extra: 0 none, 1 spurious starts while busy, 2 reset mid-EMIT
  task automatic run_group(input grp_t xs, input int mode, input int extra);
    int sh = m_shift(xs);
    int c = 0;
    int first = -1;
    int stall = 0;
    for (int i = 0; i < LENGTH; i++) begin
      exp_d.push_back(m_q(xs[i], sh));
      exp_s.push_back(sh);
      exp_l.push_back(i == LENGTH - 1);
    end
    hs_cnt = 0;
    @(posedge clk); #1;
    for (int i = 0; i < LENGTH; i++) bus.in_flat[i*IN_W +: IN_W] = xs[i][IN_W-1:0];
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < LENGTH; i++) bus.in_flat[i*IN_W +: IN_W] = IN_W'($urandom);
    while (exp_d.size() > 0 && c < 400) begin
      bus.start = 1'b0;
      if (mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        bus.out_ready = !(exp_d.size() == LENGTH - 3 && stall < 5);
        if (!bus.out_ready) stall++;
      end else bus.out_ready = 1'b1;
      if (extra == 1 && (c == 4 || c == 22 || exp_d.size() == 1)) bus.start = 1'b1;
      if (extra == 2 && exp_d.size() == LENGTH / 2) begin
        rst = 1'b1;
        @(posedge clk); #1;
        exp_d.delete();
        exp_s.delete();
        exp_l.delete();
        check_idle("reset_mid_emit");
        rst = 1'b0;
        break;
      end
      @(posedge clk); #1;
      c++;
      if (first < 0 && bus.out_valid) first = c;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    if (extra != 2) begin
      if (exp_d.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL timeout: %0d outputs still pending", exp_d.size());
        exp_d.delete();
        exp_s.delete();
        exp_l.delete();
      end
      chk("handshakes", hs_cnt, LENGTH);
      chk("latency", first, LENGTH + 1);
      if (mode == 2) chk("stall_len", stall, 5);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_valid", int'(bus.out_valid), 0);
  endtask

  grp_t g;

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_flat = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    foreach (g[i]) g[i] = 10 * i + 1;
    chk("model_t2_shift", m_shift(g), 1);
`ifdef QUANT_ROUND_EN
    chk("model_t2_e15", m_q(151, 1), 76);
    chk("model_t2_e0", m_q(1, 1), 1);
    chk("model_t3_other", m_q(256, 9), 1);
    chk("model_t4_e0", m_q(32767, 8), 127);
`else
    chk("model_t2_e15", m_q(151, 1), 75);
    chk("model_t2_e0", m_q(1, 1), 0);
    chk("model_t3_other", m_q(256, 9), 0);
    chk("model_t4_e0", m_q(32767, 8), 127);
`endif
    chk("model_t3_e7", m_q(-32768, 9), -64);

    foreach (g[i]) g[i] = 0;
    chk("model_t1_shift", m_shift(g), 0);
    run_group(g, 0, 0);

    foreach (g[i]) g[i] = 10 * i + 1;
    run_group(g, 0, 0);

    foreach (g[i]) g[i] = 256;
    g[7] = -32768;
    chk("model_t3_shift", m_shift(g), 9);
    run_group(g, 0, 0);

    foreach (g[i]) g[i] = 0;
    g[0] = 32767;
    chk("model_t4_shift", m_shift(g), 8);
    run_group(g, 0, 0);

    foreach (g[i]) g[i] = 10 * i + 1;
    run_group(g, 2, 0);

    foreach (g[i]) g[i] = 300 - 37 * i;
    run_group(g, 0, 1);

    foreach (g[i]) g[i] = 1000 * i - 7000;
    run_group(g, 0, 2);

    foreach (g[i]) g[i] = 10 * i + 1;
    run_group(g, 1, 0);

    for (int n = 0; n < 10; n++) begin
      int amp = $urandom_range(0, 15);
      foreach (g[i])
        g[i] = int'($urandom_range(0, (1 << (amp + 1)) - 1)) - (1 << amp);
      if (n == 3) g[$urandom_range(0, LENGTH - 1)] = -32768;
      run_group(g, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
